// File: rtl/fetch_decode_if.sv
// fetch_decode_if
//   Bundles the instruction ROM port and the control-unit (CU) port of
//   fetch_decode.
//   ROM:  rom_address, rom_read_enable (master out), rom_data (master in)
//   CU:   opcode, dest, src (master out), cu_state (master in)
//   master: the fetch/decode sequencer; slave: the ROM and CU side.
interface fetch_decode_if;
  logic [7:0]  rom_address;
  logic        rom_read_enable;
  logic [15:0] rom_data;
  logic [3:0]  opcode;
  logic [5:0]  dest;
  logic [5:0]  src;
  logic [2:0]  cu_state;

  modport master (
    output rom_address, rom_read_enable, opcode, dest, src,
    input  rom_data, cu_state
  );

  modport slave (
    input  rom_address, rom_read_enable, opcode, dest, src,
    output rom_data, cu_state
  );
endinterface

// File: rtl/fetch_decode.sv
// fetch_decode
//   Instruction fetch/decode sequencer. Reads 16-bit words from a ROM,
//   executes NOP/JMP/HALT locally and hands every other opcode to a control
//   unit, waiting for it to report completion (or timing out).
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           start from pc=0 (honoured only in IDLE and HALT)
//   bus (master)    ROM read port and CU command/status port
//   pc              current program counter
//   busy            high in every state except IDLE and HALT
//   halted          high in HALT
//   timeout_err     sticky, set when the CU fails to finish within TIMEOUT
//   instr_count     saturating count of instructions issued to the CU
//
// state  | meaning
// IDLE   | after reset, waiting for start
// FETCH  | ROM read strobe high, address = pc
// WAIT   | ROM data arrives, captured into ir at end of cycle
// DECODE | ir examined, next step chosen
// ISSUE  | command held on the CU port until done or timeout
// CLEAR  | opcode 0 on the CU port until the CU reports idle
// HALT   | program stopped, waiting for start
module fetch_decode #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  fetch_decode_if.master bus,
  output logic [7:0]     pc,
  output logic           busy,
  output logic           halted,
  output logic           timeout_err,
  output logic [15:0]    instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_ISSUE  = 3'd4;
  localparam logic [2:0] S_CLEAR  = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_RSV  = 4'b1110;
  localparam logic [3:0] OP_JMP  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] CU_DONE = 3'b111;
  localparam logic [2:0] CU_IDLE = 3'b000;

  // tcnt holds the number of ISSUE cycles already completed, so the
  // TIMEOUT-th ISSUE cycle is the one where tcnt equals TIMEOUT-1.
  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [7:0]  pc_nxt;
  logic [15:0] ir;
  logic [3:0]  ir_op;
  logic [7:0]  tcnt;
  logic        issue_go;
  logic        tmo_hit;

  assign ir_op  = ir[15:12];
  assign busy   = (state != S_IDLE) && (state != S_HALT);
  assign halted = (state == S_HALT);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    issue_go  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = 8'h00;
        end
      end
      S_FETCH:  state_nxt = S_WAIT;
      S_WAIT:   state_nxt = S_DECODE;
      S_DECODE: begin
        case (ir_op)
          OP_NOP, OP_RSV: begin
            state_nxt = S_FETCH;
            pc_nxt    = pc + 8'd1;
          end
          OP_JMP: begin
            state_nxt = S_FETCH;
            pc_nxt    = ir[7:0];
          end
          OP_HALT: state_nxt = S_HALT;
          default: begin
            state_nxt = S_ISSUE;
            issue_go  = 1'b1;
          end
        endcase
      end
      S_ISSUE: begin
        // completion is checked first so it wins over a coincident timeout
        if (bus.cu_state == CU_DONE) begin
          state_nxt = S_CLEAR;
        end else if (tcnt == TCNT_LAST) begin
          state_nxt = S_CLEAR;
          tmo_hit   = 1'b1;
        end
      end
      S_CLEAR: begin
        if (bus.cu_state == CU_IDLE) begin
          state_nxt = S_FETCH;
          pc_nxt    = pc + 8'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      pc                  <= 8'h00;
      ir                  <= 16'h0000;
      tcnt                <= 8'h00;
      timeout_err         <= 1'b0;
      instr_count         <= 16'h0000;
      bus.rom_address     <= 8'h00;
      bus.rom_read_enable <= 1'b0;
      bus.opcode          <= 4'h0;
      bus.dest            <= 6'h00;
      bus.src             <= 6'h00;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;

      // ROM strobe/address are registered from the next state so they are
      // valid for exactly the FETCH cycle
      bus.rom_read_enable <= (state_nxt == S_FETCH);
      if (state_nxt == S_FETCH) begin
        bus.rom_address <= pc_nxt;
      end

      if (state == S_WAIT) begin
        ir <= bus.rom_data;
      end

      if (issue_go) begin
        bus.opcode <= ir_op;
        bus.dest   <= ir[11:6];
        bus.src    <= ir[5:0];
        tcnt       <= 8'h00;
        if (instr_count != 16'hFFFF) begin
          instr_count <= instr_count + 16'd1;
        end
      end else begin
        if (state_nxt != S_ISSUE) begin
          bus.opcode <= 4'h0;
        end
        if (state == S_ISSUE) begin
          tcnt <= tcnt + 8'd1;
        end
      end

      if (tmo_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
module tb_fetch_decode;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic        timeout_err;
  logic [15:0] instr_count;

  int errors = 0;
  int checks = 0;

  fetch_decode_if bus ();

  fetch_decode #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .timeout_err (timeout_err),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // ROM model: data valid one cycle after a read-enabled edge
  logic [15:0] rom [256];
  always @(posedge clk) begin
    if (bus.rom_read_enable) bus.rom_data <= rom[bus.rom_address];
  end

  // CU model: reports done once opcode has been nonzero for cu_done_at edges
  int         cu_cnt = 0;
  int         cu_done_at = 2;
  bit         cu_hold = 1'b0;
  bit         cu_ovr_en = 1'b0;
  logic [2:0] cu_ovr_val = 3'b000;
  always @(posedge clk) cu_cnt <= (bus.opcode != 4'h0) ? cu_cnt + 1 : 0;
  assign bus.cu_state = cu_ovr_en ? cu_ovr_val :
                        (bus.opcode == 4'h0) ? 3'b000 :
                        (!cu_hold && cu_cnt >= cu_done_at) ? 3'b111 : 3'b001;

  int re_cnt = 0;
  always @(posedge clk) if (bus.rom_read_enable) re_cnt <= re_cnt + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rom_fill(input logic [15:0] w);
    for (int i = 0; i < 256; i++) rom[i] = w;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; cu_ovr_en = 1'b0; cu_hold = 1'b0; cu_done_at = 2;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({pc, bus.rom_address, bus.rom_read_enable, bus.opcode, bus.dest, bus.src} !== 33'h0) begin
      errors++;
      $display("FAIL reset_bus: got pc=%h addr=%h re=%b op=%h d=%h s=%h, expected all 0",
               pc, bus.rom_address, bus.rom_read_enable, bus.opcode, bus.dest, bus.src);
    end
    checks++;
    if ({busy, halted, timeout_err, instr_count} !== 19'h0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b halted=%b terr=%b cnt=%h, expected 0",
               busy, halted, timeout_err, instr_count);
    end
    tick(2);
    rst_n = 1'b1;
    tick(3);
    checks++;
    if ({busy, bus.rom_read_enable} !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_start: got busy=%b re=%b, expected 0 0", busy, bus.rom_read_enable);
    end
  endtask

  task automatic test_mov();
    apply_reset();
    rom_fill(16'hF000);
    rom[0] = 16'h1042;
    cu_done_at = 2;
    pulse_start();
    checks++;
    if ({bus.rom_read_enable, bus.rom_address, busy} !== {1'b1, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL mov_fetch: got re=%b addr=%h busy=%b, expected 1 00 1",
               bus.rom_read_enable, bus.rom_address, busy);
    end
    tick(3);
    checks++;
    if ({bus.opcode, bus.dest, bus.src, instr_count} !== {4'h1, 6'd1, 6'd2, 16'd1}) begin
      errors++;
      $display("FAIL mov_issue: got op=%h d=%0d s=%0d cnt=%0d, expected 1 1 2 1",
               bus.opcode, bus.dest, bus.src, instr_count);
    end
    tick(2);
    checks++;
    if (bus.opcode !== 4'h1) begin
      errors++;
      $display("FAIL mov_issue_hold: got op=%h, expected 1", bus.opcode);
    end
    tick(1);
    checks++;
    if ({bus.opcode, bus.dest, bus.src, pc, busy} !== {4'h0, 6'd1, 6'd2, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL mov_clear: got op=%h d=%0d s=%0d pc=%h busy=%b, expected 0 1 2 00 1",
               bus.opcode, bus.dest, bus.src, pc, busy);
    end
    tick(1);
    checks++;
    if ({pc, bus.rom_address, bus.rom_read_enable} !== {8'h01, 8'h01, 1'b1}) begin
      errors++;
      $display("FAIL mov_next_fetch: got pc=%h addr=%h re=%b, expected 01 01 1",
               pc, bus.rom_address, bus.rom_read_enable);
    end
    tick(3);
    checks++;
    if ({halted, busy, pc, instr_count} !== {1'b1, 1'b0, 8'h01, 16'd1}) begin
      errors++;
      $display("FAIL mov_halt: got halted=%b busy=%b pc=%h cnt=%0d, expected 1 0 01 1",
               halted, busy, pc, instr_count);
    end
  endtask

  task automatic test_jmp();
    int re0;
    apply_reset();
    rom_fill(16'hF000);
    rom[0] = 16'hD005;
    rom[5] = 16'hF000;
    re0 = re_cnt;
    pulse_start();
    tick(3);
    checks++;
    if ({pc, bus.rom_address, bus.rom_read_enable} !== {8'h05, 8'h05, 1'b1}) begin
      errors++;
      $display("FAIL jmp_target: got pc=%h addr=%h re=%b, expected 05 05 1",
               pc, bus.rom_address, bus.rom_read_enable);
    end
    tick(6);
    checks++;
    if ({halted, pc, instr_count, bus.opcode} !== {1'b1, 8'h05, 16'd0, 4'h0}) begin
      errors++;
      $display("FAIL jmp_halt: got halted=%b pc=%h cnt=%0d op=%h, expected 1 05 0 0",
               halted, pc, instr_count, bus.opcode);
    end
    checks++;
    if (re_cnt - re0 !== 2) begin
      errors++;
      $display("FAIL jmp_re_pulses: got %0d, expected 2", re_cnt - re0);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    rom_fill(16'hF000);
    rom[0] = 16'h1042;
    rom[1] = 16'h2345;
    cu_done_at = 0;
    pulse_start();
    tick(3);
    checks++;
    if (bus.opcode !== 4'h1) begin
      errors++;
      $display("FAIL b2b_first_issue: got op=%h, expected 1", bus.opcode);
    end
    tick(2);
    start = 1'b1;  // must be ignored while running
    checks++;
    if ({pc, bus.rom_address} !== {8'h01, 8'h01}) begin
      errors++;
      $display("FAIL b2b_second_fetch: got pc=%h addr=%h, expected 01 01", pc, bus.rom_address);
    end
    tick(3);
    checks++;
    if ({bus.opcode, bus.dest, bus.src, pc, instr_count} !== {4'h2, 6'd13, 6'd5, 8'h01, 16'd2}) begin
      errors++;
      $display("FAIL b2b_second_issue: got op=%h d=%0d s=%0d pc=%h cnt=%0d, expected 2 13 5 01 2",
               bus.opcode, bus.dest, bus.src, pc, instr_count);
    end
    start = 1'b0;
    tick(5);
    checks++;
    if ({halted, pc, instr_count} !== {1'b1, 8'h02, 16'd2}) begin
      errors++;
      $display("FAIL b2b_halt: got halted=%b pc=%h cnt=%0d, expected 1 02 2", halted, pc, instr_count);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    rom_fill(16'hF000);
    rom[0] = 16'h4000;
    cu_hold = 1'b1;
    pulse_start();
    tick(3);
    tick(15);
    checks++;
    if ({bus.opcode, timeout_err} !== {4'h4, 1'b0}) begin
      errors++;
      $display("FAIL tmo_cycle16: got op=%h terr=%b, expected 4 0", bus.opcode, timeout_err);
    end
    tick(1);
    checks++;
    if ({bus.opcode, timeout_err, pc} !== {4'h0, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL tmo_clear: got op=%h terr=%b pc=%h, expected 0 1 00", bus.opcode, timeout_err, pc);
    end
    tick(1);
    checks++;
    if ({pc, bus.rom_read_enable} !== {8'h01, 1'b1}) begin
      errors++;
      $display("FAIL tmo_advance: got pc=%h re=%b, expected 01 1", pc, bus.rom_read_enable);
    end
    tick(3);
    pulse_start();
    checks++;
    if ({pc, bus.rom_address, timeout_err, halted, busy} !== {8'h00, 8'h00, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL halt_restart: got pc=%h addr=%h terr=%b halted=%b busy=%b, expected 00 00 1 0 1",
               pc, bus.rom_address, timeout_err, halted, busy);
    end
  endtask

  task automatic test_late_done();
    apply_reset();
    rom_fill(16'hF000);
    rom[0] = 16'h2345;
    cu_done_at = 15;
    pulse_start();
    tick(3 + 15);
    checks++;
    if (bus.opcode !== 4'h2) begin
      errors++;
      $display("FAIL late_done_issue: got op=%h, expected 2", bus.opcode);
    end
    tick(1);
    checks++;
    if ({bus.opcode, timeout_err, busy} !== {4'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL late_done_clear: got op=%h terr=%b busy=%b, expected 0 0 1",
               bus.opcode, timeout_err, busy);
    end
  endtask

  task automatic test_clear_hold();
    apply_reset();
    rom_fill(16'hF000);
    rom[0] = 16'h3FFF;
    cu_hold = 1'b1;
    pulse_start();
    tick(3);
    cu_ovr_en = 1'b1;
    cu_ovr_val = 3'b111;
    tick(1);
    cu_ovr_val = 3'b010;
    tick(3);
    checks++;
    if ({bus.opcode, bus.dest, bus.src, pc, bus.rom_read_enable, busy} !==
        {4'h0, 6'd63, 6'd63, 8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL clear_hold: got op=%h d=%0d s=%0d pc=%h re=%b busy=%b, expected 0 63 63 00 0 1",
               bus.opcode, bus.dest, bus.src, pc, bus.rom_read_enable, busy);
    end
    cu_ovr_val = 3'b000;
    tick(1);
    checks++;
    if ({pc, bus.rom_read_enable} !== {8'h01, 1'b1}) begin
      errors++;
      $display("FAIL clear_release: got pc=%h re=%b, expected 01 1", pc, bus.rom_read_enable);
    end
    cu_ovr_en = 1'b0;
  endtask

  task automatic test_nop_wrap();
    int bad_busy = 0;
    int bad_op = 0;
    apply_reset();
    rom_fill(16'h0000);
    rom[8'hE0] = 16'hE123;
    pulse_start();
    for (int i = 0; i < 255; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (busy !== 1'b1) bad_busy++;
        if (bus.opcode !== 4'h0) bad_op++;
        tick(1);
      end
    end
    checks++;
    if ({pc, bus.rom_address, bus.rom_read_enable} !== {8'hFF, 8'hFF, 1'b1}) begin
      errors++;
      $display("FAIL nop_pc_ff: got pc=%h addr=%h re=%b, expected ff ff 1",
               pc, bus.rom_address, bus.rom_read_enable);
    end
    tick(3);
    checks++;
    if ({pc, bus.rom_address, busy} !== {8'h00, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL nop_wrap: got pc=%h addr=%h busy=%b, expected 00 00 1", pc, bus.rom_address, busy);
    end
    checks++;
    if ({bad_busy, bad_op} !== 64'd0 || instr_count !== 16'd0) begin
      errors++;
      $display("FAIL nop_quiet: got busy_drops=%0d op_nonzero=%0d cnt=%0d, expected 0 0 0",
               bad_busy, bad_op, instr_count);
    end
  endtask

  task automatic test_reset_mid_issue();
    apply_reset();
    rom_fill(16'hF000);
    rom[0] = 16'h0000;
    rom[1] = 16'h2345;
    cu_hold = 1'b1;
    pulse_start();
    tick(6);
    tick(2);
    checks++;
    if ({bus.opcode, pc, instr_count} !== {4'h2, 8'h01, 16'd1}) begin
      errors++;
      $display("FAIL pre_reset_issue: got op=%h pc=%h cnt=%0d, expected 2 01 1", bus.opcode, pc, instr_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.opcode, bus.dest, bus.src, pc, instr_count, busy, bus.rom_read_enable} !== 43'h0) begin
      errors++;
      $display("FAIL async_reset: got op=%h d=%h s=%h pc=%h cnt=%h busy=%b re=%b, expected all 0",
               bus.opcode, bus.dest, bus.src, pc, instr_count, busy, bus.rom_read_enable);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cu_hold = 1'b0;
    cu_done_at = 1;
    tick(2);
    checks++;
    if ({busy, bus.rom_read_enable} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b re=%b, expected 0 0", busy, bus.rom_read_enable);
    end
    pulse_start();
    checks++;
    if ({pc, bus.rom_address, bus.rom_read_enable} !== {8'h00, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL refetch_pc0: got pc=%h addr=%h re=%b, expected 00 00 1",
               pc, bus.rom_address, bus.rom_read_enable);
    end
    tick(6);
    checks++;
    if ({bus.opcode, instr_count} !== {4'h2, 16'd1}) begin
      errors++;
      $display("FAIL refetch_issue: got op=%h cnt=%0d, expected 2 1", bus.opcode, instr_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mov();
    test_jmp();
    test_back_to_back();
    test_timeout();
    test_late_done();
    test_clear_hold();
    test_nop_wrap();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
